prdct_bht: RTL
==============

// Module: prdct_bht
// PURPOSE
//  Dynamic branch predictor replacing the static BTFN ID-stage predictor. It sits beside if_id and decodes
//  the ID-stage instruction. B-type branches use a PC-indexed table of saturating counters, with the static
//  BTFN rule as fallback. JAL is always taken. JALR uses a return-address stack (RAS) for returns, else the
//  forwarded rs1. Resolution from EX trains the table and counts mispredicts.
// PARAMETERS
//  BHT_DEPTH  64  counter-table entries; power of 2, >=4; IDX_W=log2(BHT_DEPTH)
//  CNT_W      2   counter width; taken when MSB=1
//  RAS_DEPTH  4   return-stack entries; power of 2, >=2
//  ADDR_W     32  instruction address width
// PORTS
//  clk               in   1       clock, rising edge
//  rstn              in   1       synchronous reset, active low
//  id_valid_i        in   1       inst_i valid in ID (not bubble/flushed)
//  id_stall_i        in   1       ID held this cycle; suppresses RAS push/pop
//  inst_i            in   32      ID-stage instruction
//  instaddr_i        in   ADDR_W  ID-stage instruction address
//  rs1_fwd_i         in   32      rs1 value, already forwarded from EX/MEM
//  prd_jump_en_o     out  1       predict redirect
//  prd_jump_base_o   out  ADDR_W  target base
//  prd_jump_ofset_o  out  32      target offset; target = base+offset
//  ex_br_valid_i     in   1       B-type resolved in EX this cycle
//  ex_br_pc_i        in   ADDR_W  resolved branch PC
//  ex_br_taken_i     in   1       actual outcome
//  ex_mispred_i      in   1       EX redirect due to any mispredict (B or JALR)
//  mispred_cnt_o     out  32      mispredict count, saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  Reset (rstn=0 at a posedge):
//   - all counters become weakly-not-taken (01 for CNT_W=2, i.e. 2^(CNT_W-1)-1)
//   - all entry valid bits clear; RAS pointer 0, RAS count 0; mispred_cnt_o 0
//   - while rstn=0, prd_jump_en_o=0, base=CpuResetAddr, offset=0
//  Lookup (combinational, same cycle):
//   - idx = instaddr_i[IDX_W+1:2]
//   - outputs are 0 / CpuResetAddr / 0 when id_valid_i=0 or opcode is not B/JAL/JALR
//   - B-type: base=instaddr_i, offset=imm_b sign-extended
//       en = counter MSB if valid[idx], else imm_b sign bit (BTFN fallback)
//   - JAL: en=1, base=instaddr_i, offset=imm_j sign-extended
//   - JALR, return (rs1 in {x1,x5}, rd not in {x1,x5}, RAS count>0):
//       en=1, base=RAS top, offset=0
//   - any other JALR: en=1, base=rs1_fwd_i, offset=imm_i sign-extended
//  RAS update (posedge; only when id_valid_i=1 and id_stall_i=0):
//   - push instaddr_i+4 on JAL/JALR with rd in {x1,x5}
//   - pop on a JALR return as defined above
//   - push while full: overwrite the oldest entry (circular); count stays RAS_DEPTH
//   - pop while empty: no change, and the JALR falls back to rs1
//   - JALR with rs1,rd both link regs and rs1!=rd: pop then push in the same cycle (coroutine)
//   - no repair on flush; wrong-path pushes and pops are tolerated
//  Training (posedge, ex_br_valid_i=1), ui = ex_br_pc_i[IDX_W+1:2]:
//   - valid[ui] set to 1
//   - counter increments if taken, else decrements; saturates at all-1 / 0
//   - counter update is based on the stored value, even if the entry was invalid
//   - lookup and training on the same index in one cycle: lookup sees the pre-update value
//  Counter: mispred_cnt_o increments by 1 per cycle with ex_mispred_i=1; saturates at max.
//  Latency: predict 0 cycles; training visible to lookups 1 cycle after the update edge.
// TESTING
//  1 After reset, B with imm=-8 @0x100 -> en=1, base 0x100, offset 0xFFFFFFF8 (BTFN).
//    Same instruction with imm=+8 -> en=0.
//  2 Train pc 0x200 taken x2 -> forward B @0x200 predicts en=1.
//    Then 3 not-taken -> en=0; counter at 0, stays 0 after a 4th not-taken.
//  3 JAL x1 @0x300 then JALR x0,0(x1) -> JALR en=1, base=0x304, offset 0.
//    Count returns to 0; a second JALR uses rs1_fwd_i.
//  4 Push 5 calls with RAS_DEPTH=4 -> 4 pops yield calls 5,4,3,2; 5th pop falls back to rs1.
//  5 Train idx 3 on the same cycle as a lookup @idx 3 -> old prediction.
//    Next cycle -> updated prediction.
//  6 ex_mispred_i held 3 cycles -> mispred_cnt_o=3; rstn=0 mid-run -> count 0, table back to BTFN.

Source files
------------

// File: rtl/prdct_bht.sv
// ID-stage branch predictor: PC-indexed saturating counters with a BTFN fallback for
// untrained entries, always-taken JAL, and a circular return-address stack for JALR.
module prdct_bht #(
  parameter int                BHT_DEPTH      = 64,
  parameter int                CNT_W          = 2,
  parameter int                RAS_DEPTH      = 4,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] CPU_RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_valid_i,
  input  logic              id_stall_i,
  input  logic [31:0]       inst_i,
  input  logic [ADDR_W-1:0] instaddr_i,
  input  logic [31:0]       rs1_fwd_i,
  output logic              prd_jump_en_o,
  output logic [ADDR_W-1:0] prd_jump_base_o,
  output logic [31:0]       prd_jump_ofset_o,
  input  logic              ex_br_valid_i,
  input  logic [ADDR_W-1:0] ex_br_pc_i,
  input  logic              ex_br_taken_i,
  input  logic              ex_mispred_i,
  output logic [31:0]       mispred_cnt_o
);
  localparam int               IDX_W    = $clog2(BHT_DEPTH);
  localparam int               PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PTR_W:0]   RAS_FULL = (PTR_W+1)'(RAS_DEPTH);
  localparam logic [6:0]       OP_BR    = 7'b1100011;
  localparam logic [6:0]       OP_JAL   = 7'b1101111;
  localparam logic [6:0]       OP_JALR  = 7'b1100111;

  logic [CNT_W-1:0]     cnt_q [BHT_DEPTH];
  logic [BHT_DEPTH-1:0] valid_q;
  logic [ADDR_W-1:0]    ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]     ras_ptr_q, ras_ptr_d;
  logic [PTR_W:0]       ras_cnt_q, ras_cnt_d;
  logic [31:0]          mispred_cnt_q;

  logic [4:0]       rd, rs1;
  logic             is_b, is_jal, is_jalr, rd_link, rs1_link, is_ret;
  logic             ras_upd, do_pop, do_push;
  logic [31:0]      imm_b, imm_j, imm_i;
  logic [IDX_W-1:0] idx, ui;
  logic [PTR_W-1:0] ras_top_ptr, ras_wr_ptr;
  logic [CNT_W-1:0] tr_old, tr_new;
  logic             unused_bits;

  assign rd       = inst_i[11:7];
  assign rs1      = inst_i[19:15];
  assign is_b     = (inst_i[6:0] == OP_BR);
  assign is_jal   = (inst_i[6:0] == OP_JAL);
  assign is_jalr  = (inst_i[6:0] == OP_JALR);
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign imm_b    = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j    = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_i    = {{20{inst_i[31]}}, inst_i[31:20]};
  assign idx      = instaddr_i[IDX_W+1:2];
  assign ui       = ex_br_pc_i[IDX_W+1:2];

  assign unused_bits = ^{inst_i[14:12], ex_br_pc_i[ADDR_W-1:IDX_W+2], ex_br_pc_i[1:0]};

  // A return is predicted only from a non-empty stack; otherwise it falls back to rs1.
  assign is_ret      = is_jalr && rs1_link && !rd_link && (ras_cnt_q != '0);
  assign ras_top_ptr = ras_ptr_q - PTR_W'(1);
  assign ras_upd     = id_valid_i && !id_stall_i;
  assign do_pop      = ras_upd && is_jalr && rs1_link && (!rd_link || (rs1 != rd)) &&
                       (ras_cnt_q != '0);
  assign do_push     = ras_upd && (is_jal || is_jalr) && rd_link;
  assign ras_wr_ptr  = do_pop ? ras_top_ptr : ras_ptr_q;

  always_comb begin
    prd_jump_en_o    = 1'b0;
    prd_jump_base_o  = CPU_RESET_ADDR;
    prd_jump_ofset_o = '0;
    if (rstn && id_valid_i) begin
      if (is_b) begin
        prd_jump_en_o    = valid_q[idx] ? cnt_q[idx][CNT_W-1] : imm_b[31];
        prd_jump_base_o  = instaddr_i;
        prd_jump_ofset_o = imm_b;
      end else if (is_jal) begin
        prd_jump_en_o    = 1'b1;
        prd_jump_base_o  = instaddr_i;
        prd_jump_ofset_o = imm_j;
      end else if (is_jalr) begin
        prd_jump_en_o = 1'b1;
        if (is_ret) begin
          prd_jump_base_o = ras_q[ras_top_ptr];
        end else begin
          prd_jump_base_o  = ADDR_W'(rs1_fwd_i);
          prd_jump_ofset_o = imm_i;
        end
      end
    end
  end

  // Pop happens first so a coroutine JALR replaces the top entry in place.
  always_comb begin
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (do_pop) begin
      ras_ptr_d = ras_top_ptr;
      ras_cnt_d = ras_cnt_q - (PTR_W+1)'(1);
    end
    if (do_push) begin
      ras_ptr_d = ras_wr_ptr + PTR_W'(1);
      if (ras_cnt_d != RAS_FULL) begin
        ras_cnt_d = ras_cnt_d + (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && do_push) begin
      ras_q[ras_wr_ptr] <= instaddr_i + ADDR_W'(4);
    end
  end

  assign tr_old = cnt_q[ui];
  always_comb begin
    tr_new = tr_old;
    if (ex_br_taken_i) begin
      if (tr_old != CNT_MAX) tr_new = tr_old + CNT_W'(1);
    end else begin
      if (tr_old != '0) tr_new = tr_old - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) cnt_q[i] <= CNT_INIT;
    end else if (ex_br_valid_i) begin
      valid_q[ui] <= 1'b1;
      cnt_q[ui]   <= tr_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mispred_cnt_q <= '0;
    end else if (ex_mispred_i && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
      mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign mispred_cnt_o = mispred_cnt_q;
endmodule
